id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage directly downstream of the register file.
- Captures the register-file read ports PA/PB/PD plus decoded control.
- Resolves data hazards in two ways: operand forwarding from EX, MEM and WB, and a one-cycle load-use stall.
- Drives the HZPCld (PC load enable) and IF/ID load enable consumed upstream.

Parameters:
- CW, 8: width of the opaque decoded-control bundle carried ID->EX.
- CNTW, 16: width of the saturating stall-event counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- PA, PB, PD  in  32 each  register-file read data.
- SA, SB, SD  in  4 each  register-file read selectors.
- USE_A, USE_B, USE_D  in  1 each  ID instruction actually consumes that operand.
- ID_CTRL  in  CW  decoded control of ID instruction.
- ID_RD  in  4  destination register of ID instruction.
- ID_RFLD  in  1  ID instruction writes the register file.
- ID_MEMRD  in  1  ID instruction is a load.
- EX_RESULT  in  32  combinational ALU result of the instruction now in EX.
- MEM_RD  in  4  destination of the MEM-stage instruction.
- MEM_RFLD  in  1  write enable of the MEM-stage instruction.
- MEM_RESULT  in  32  data of the MEM-stage instruction.
- WB_RD  in  4  destination of the WB-stage instruction.
- WB_RFLD  in  1  write enable of the WB-stage instruction.
- WB_RESULT  in  32  data of the WB-stage instruction (PW).
- FLUSH  in  1  squash the ID instruction (taken branch).
- EX_A, EX_B, EX_D  out  32 each  registered operands.
- EX_CTRL  out  CW  registered control.
- EX_RD  out  4  registered destination.
- EX_RFLD, EX_MEMRD  out  1 each  registered write / load flags.
- HZPCld  out  1  PC load enable (0 = hold PC).
- IFID_LD  out  1  IF/ID register load enable (0 = hold).
- STALL_CNT  out  CNTW  count of load-use stall cycles.

Behaviour:
- Reset (async, RST=1):
  - EX_A/B/D=0, EX_CTRL=0, EX_RD=0, EX_RFLD=0, EX_MEMRD=0, STALL_CNT=0.
  - Consequently HZPCld=1 and IFID_LD=1.
  - Deassertion takes effect at the next rising CLK. Reset mid-stall discards the bubble state and the counter.
- Forwarding (combinational, per operand X in {A,B,D} with selector SX):
  - Priority is EX > MEM > WB > register file.
  - EX hit: EX_RFLD=1, EX_MEMRD=0, EX_RD==SX -> EX_RESULT.
  - MEM hit: MEM_RFLD=1, MEM_RD==SX -> MEM_RESULT.
  - WB hit: WB_RFLD=1, WB_RD==SX -> WB_RESULT.
  - Otherwise -> PX.
  - SX==4'hF (R15/PC) is never forwarded; PX is always used.
- Load-use hazard (combinational):
  - HAZ = EX_RFLD & EX_MEMRD & ~FLUSH & OR over X of (USE_X & SX==EX_RD & SX!=4'hF).
  - HZPCld = ~HAZ; IFID_LD = ~HAZ.
- Register update on rising CLK, in priority order:
  - FLUSH=1: load a bubble. CTRL, RFLD, MEMRD and RD all 0; operand registers are loaded with the forwarded values (don't-care). FLUSH overrides HAZ.
  - Else HAZ=1: load the same bubble. The ID instruction is held upstream and re-evaluated next cycle, when the load sits in MEM and the MEM path forwards it. Stall length is exactly 1 cycle per load-use pair.
  - Else: capture the forwarded operands, ID_CTRL, ID_RD, ID_RFLD and ID_MEMRD.
- Latency: 1 cycle ID->EX; zero-bubble for ALU->ALU dependencies.
- STALL_CNT:
  - Increments by 1 on every rising edge where HAZ=1.
  - Saturates at all-ones (no wrap).
  - Not cleared by FLUSH.
- A load whose EX_RD matches a selector with the corresponding USE_X=0 causes no stall.
- Simultaneous hits: a match in both EX and WB with different data selects EX.

Test Plan:
- Reset: RST=1 async mid-cycle -> all outputs 0 immediately, HZPCld=1, IFID_LD=1, STALL_CNT=0.
- EX forward: ADD R3 in EX (EX_RESULT=32'd42), ID SA=3 USE_A=1, PA=7 -> next edge EX_A=42, no stall.
- Priority: MEM_RD=5 MEM_RESULT=9, WB_RD=5 WB_RESULT=11, SB=5 USE_B=1 -> EX_B=9. Repeat with MEM_RFLD=0 -> EX_B=11.
- Load-use stall:
  - Setup: LDR R2 in EX (EX_MEMRD=1), ID SD=2 USE_D=1.
  - Stall cycle: HZPCld=0, IFID_LD=0; next edge EX_RFLD=0, EX_CTRL=0, STALL_CNT=1.
  - Following cycle: MEM_RD=2, MEM_RESULT=0xDEAD -> EX_D=0xDEAD, HZPCld=1.
- Flush vs hazard: same load-use setup with FLUSH=1 -> HZPCld=1, bubble loaded, STALL_CNT unchanged.
- R15 and saturation:
  - SA=15 with EX_RD=15, EX_RFLD=1 -> EX_A=PA.
  - With CNTW=2, drive 5 stall cycles -> STALL_CNT=3.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// Bundle between the decode/register-file side and the ID/EX operand stage.
// Hold semantics: when HZPCld/IFID_LD are 0 the upstream stages keep the
// current ID instruction and its selectors stable for one more cycle; the
// stage itself never back-pressures on any other signal.
interface id_ex_operand_stage_if #(
    parameter int CW   = 8,
    parameter int CNTW = 16
);
    // Register-file read side and ID-stage decode
    logic [31:0]     PA, PB, PD;
    logic [3:0]      SA, SB, SD;
    logic            USE_A, USE_B, USE_D;
    logic [CW-1:0]   ID_CTRL;
    logic [3:0]      ID_RD;
    logic            ID_RFLD;
    logic            ID_MEMRD;

    // Forwarding sources from later stages
    logic [31:0]     EX_RESULT;
    logic [3:0]      MEM_RD;
    logic            MEM_RFLD;
    logic [31:0]     MEM_RESULT;
    logic [3:0]      WB_RD;
    logic            WB_RFLD;
    logic [31:0]     WB_RESULT;
    logic            FLUSH;

    // Registered EX-stage view and upstream hold controls
    logic [31:0]     EX_A, EX_B, EX_D;
    logic [CW-1:0]   EX_CTRL;
    logic [3:0]      EX_RD;
    logic            EX_RFLD;
    logic            EX_MEMRD;
    logic            HZPCld;
    logic            IFID_LD;
    logic [CNTW-1:0] STALL_CNT;

    // Decode/pipeline environment side
    modport master (
        output PA, PB, PD, SA, SB, SD, USE_A, USE_B, USE_D,
        output ID_CTRL, ID_RD, ID_RFLD, ID_MEMRD,
        output EX_RESULT, MEM_RD, MEM_RFLD, MEM_RESULT,
        output WB_RD, WB_RFLD, WB_RESULT, FLUSH,
        input  EX_A, EX_B, EX_D, EX_CTRL, EX_RD, EX_RFLD, EX_MEMRD,
        input  HZPCld, IFID_LD, STALL_CNT
    );

    // Operand stage side
    modport slave (
        input  PA, PB, PD, SA, SB, SD, USE_A, USE_B, USE_D,
        input  ID_CTRL, ID_RD, ID_RFLD, ID_MEMRD,
        input  EX_RESULT, MEM_RD, MEM_RFLD, MEM_RESULT,
        input  WB_RD, WB_RFLD, WB_RESULT, FLUSH,
        output EX_A, EX_B, EX_D, EX_CTRL, EX_RD, EX_RFLD, EX_MEMRD,
        output HZPCld, IFID_LD, STALL_CNT
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwards EX/MEM/WB results into the register-file
// operands, inserts a single bubble on a load-use dependency, and counts
// the stall cycles with a saturating counter.
module id_ex_operand_stage #(
    parameter int CW   = 8,
    parameter int CNTW = 16
) (
    input logic                 CLK,
    input logic                 RST,
    id_ex_operand_stage_if.slave bus
);

    localparam logic [3:0] PC_REG = 4'hF;

    // EX-stage pipeline registers
    logic [31:0]     ex_a_q, ex_b_q, ex_d_q;
    logic [CW-1:0]   ex_ctrl_q;
    logic [3:0]      ex_rd_q;
    logic            ex_rfld_q;
    logic            ex_memrd_q;
    logic [CNTW-1:0] stall_cnt_q;

    // Next-state values
    logic [31:0]     ex_a_d, ex_b_d, ex_d_d;
    logic [CW-1:0]   ex_ctrl_d;
    logic [3:0]      ex_rd_d;
    logic            ex_rfld_d;
    logic            ex_memrd_d;
    logic [CNTW-1:0] stall_cnt_d;

    logic            haz;
    logic            ex_fwd_ok;

    // Priority forward mux for one operand: EX > MEM > WB > register file.
    // R15 reads the PC value from the register file and is never bypassed.
    function automatic logic [31:0] fwd_sel(
        input logic [3:0]  sel,
        input logic [31:0] rf,
        input logic        ex_ok,
        input logic [3:0]  ex_rd,
        input logic [31:0] ex_res,
        input logic        mem_ld,
        input logic [3:0]  mem_rd,
        input logic [31:0] mem_res,
        input logic        wb_ld,
        input logic [3:0]  wb_rd,
        input logic [31:0] wb_res
    );
        logic [31:0] r;
        r = rf;
        if (sel != PC_REG) begin
            if (ex_ok && ex_rd == sel)
                r = ex_res;
            else if (mem_ld && mem_rd == sel)
                r = mem_res;
            else if (wb_ld && wb_rd == sel)
                r = wb_res;
        end
        return r;
    endfunction

    // Load-use detection and upstream hold controls
    always_comb begin
        // A load in EX has no data yet, so it may not feed the EX bypass.
        ex_fwd_ok = ex_rfld_q & ~ex_memrd_q;
        haz = ex_rfld_q & ex_memrd_q & ~bus.FLUSH &
              ((bus.USE_A & (bus.SA == ex_rd_q) & (bus.SA != PC_REG)) |
               (bus.USE_B & (bus.SB == ex_rd_q) & (bus.SB != PC_REG)) |
               (bus.USE_D & (bus.SD == ex_rd_q) & (bus.SD != PC_REG)));
    end

    // Next-state: forwarded operands, bubble on flush/hazard, counter update
    always_comb begin
        ex_a_d = fwd_sel(bus.SA, bus.PA, ex_fwd_ok, ex_rd_q, bus.EX_RESULT,
                         bus.MEM_RFLD, bus.MEM_RD, bus.MEM_RESULT,
                         bus.WB_RFLD, bus.WB_RD, bus.WB_RESULT);
        ex_b_d = fwd_sel(bus.SB, bus.PB, ex_fwd_ok, ex_rd_q, bus.EX_RESULT,
                         bus.MEM_RFLD, bus.MEM_RD, bus.MEM_RESULT,
                         bus.WB_RFLD, bus.WB_RD, bus.WB_RESULT);
        ex_d_d = fwd_sel(bus.SD, bus.PD, ex_fwd_ok, ex_rd_q, bus.EX_RESULT,
                         bus.MEM_RFLD, bus.MEM_RD, bus.MEM_RESULT,
                         bus.WB_RFLD, bus.WB_RD, bus.WB_RESULT);
        ex_ctrl_d   = '0;
        ex_rd_d     = '0;
        ex_rfld_d   = 1'b0;
        ex_memrd_d  = 1'b0;
        stall_cnt_d = stall_cnt_q;
        // Flush and hazard both load a bubble; only the hazard stalls.
        if (!bus.FLUSH && !haz) begin
            ex_ctrl_d  = bus.ID_CTRL;
            ex_rd_d    = bus.ID_RD;
            ex_rfld_d  = bus.ID_RFLD;
            ex_memrd_d = bus.ID_MEMRD;
        end
        if (haz && (stall_cnt_q != {CNTW{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Pipeline register and stall counter update
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_d_q      <= '0;
            ex_ctrl_q   <= '0;
            ex_rd_q     <= '0;
            ex_rfld_q   <= 1'b0;
            ex_memrd_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            ex_d_q      <= ex_d_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            ex_rfld_q   <= ex_rfld_d;
            ex_memrd_q  <= ex_memrd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.EX_A      = ex_a_q;
    assign bus.EX_B      = ex_b_q;
    assign bus.EX_D      = ex_d_q;
    assign bus.EX_CTRL   = ex_ctrl_q;
    assign bus.EX_RD     = ex_rd_q;
    assign bus.EX_RFLD   = ex_rfld_q;
    assign bus.EX_MEMRD  = ex_memrd_q;
    assign bus.HZPCld    = ~haz;
    assign bus.IFID_LD   = ~haz;
    assign bus.STALL_CNT = stall_cnt_q;

endmodule
